// File: rtl/dircc_types_pkg.sv
// Shared types for the dircc processing-element datapath.
package dircc_types_pkg;

    localparam int DIRCC_DATA_WIDTH  = 32;
    localparam int DIRCC_EMPTY_WIDTH = 2;

    typedef enum logic [1:0] {
        INGRESS_IDLE    = 2'd0,
        INGRESS_ACCEPT  = 2'd1,
        INGRESS_DISCARD = 2'd2
    } ingress_state_t;

    // Storage layout of one buffered beat at the default bus width
    typedef struct packed {
        logic [DIRCC_DATA_WIDTH-1:0]  data;
        logic [DIRCC_EMPTY_WIDTH-1:0] empty;
        logic                         eop;
    } ingress_entry_t;

endpackage

// File: rtl/dircc_ingress_beat_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module dircc_ingress_beat_ram #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_o <= mem_q[rdAddr_i];
        end
    end

endmodule

// File: rtl/dircc_packet_ingress_buffer.sv
// Store-and-forward Avalon-ST ingress buffer with hardware-address filtering.
// Only whole packets become visible downstream; partial packets roll back.
module dircc_packet_ingress_buffer
    import dircc_types_pkg::*;
#(
    parameter int BITS_PER_SYMBOL   = 8,
    parameter int SYMBOLS_PER_BEAT  = 4,
    parameter int FIFO_DEPTH        = 16,
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int FILTER_ENABLE     = 1,
    parameter int COUNT_WIDTH       = 16,
    localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
    localparam int EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT),
    localparam int PW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [EMPTY_WIDTH-1:0]       in_empty,
    input  logic                         in_startofpacket,
    input  logic                         in_endofpacket,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [EMPTY_WIDTH-1:0]       out_empty,
    output logic                         out_startofpacket,
    output logic                         out_endofpacket,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic [ADDRESS_MEM_WIDTH-1:0] address,
    output logic [COUNT_WIDTH-1:0]       drop_count,
    output logic [COUNT_WIDTH-1:0]       error_count,
    output logic [PW-1:0]                packets_pending
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + EMPTY_WIDTH + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

    ingress_state_t          state_q, state_d;
    logic [PW-1:0]           wrPtr_q, wrPtr_d;
    logic [PW-1:0]           commitPtr_q, commitPtr_d;
    logic [PW-1:0]           rdPtr_q, rdPtr_d;
    logic [PW-1:0]           pending_q, pending_d;
    logic [COUNT_WIDTH-1:0]  dropCnt_q, errCnt_q;
    logic                    alive_q;

    logic                    s1Valid_q;
    logic                    outValid_q, outSop_q, outEop_q, sopNext_q;
    logic [DATA_WIDTH-1:0]   outData_q;
    logic [EMPTY_WIDTH-1:0]  outEmpty_q;

    logic                    full, inReady, inFire, addrMatch;
    logic                    ramWe, ramRe, load2, popEop, commitInc, errInc;
    logic [1:0]              dropInc;
    logic [PW-2:0]           ramWaddr;
    logic [ENTRY_WIDTH-1:0]  ramRdata;
    logic [DATA_WIDTH-1:0]   ramData;
    logic [EMPTY_WIDTH-1:0]  ramEmpty;
    logic                    ramEop;

    function automatic logic [COUNT_WIDTH-1:0] satAdd(input logic [COUNT_WIDTH-1:0] cnt,
                                                      input logic [1:0] inc);
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (COUNT_WIDTH+1)'(inc);
        return sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : sum[COUNT_WIDTH-1:0];
    endfunction

    // With wr == commit outside ACCEPT, full here means committed data fills the store
    always_comb begin
        full      = (wrPtr_q - rdPtr_q) == DEPTH_P;
        inReady   = alive_q && !full;
        inFire    = in_valid && inReady;
        addrMatch = (FILTER_ENABLE == 0) || (in_data[ADDRESS_MEM_WIDTH-1:0] == address);
    end

    // A new sop always starts at commitPtr_q, which also rolls back any open packet
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        commitPtr_d = commitPtr_q;
        ramWe       = 1'b0;
        ramWaddr    = wrPtr_q[PW-2:0];
        dropInc     = 2'd0;
        errInc      = 1'b0;
        commitInc   = 1'b0;
        if (state_q == INGRESS_ACCEPT && full && commitPtr_q == rdPtr_q) begin
            wrPtr_d = commitPtr_q;
            errInc  = 1'b1;
            state_d = INGRESS_DISCARD;
        end else if (inFire) begin
            if (in_startofpacket) begin
                if (state_q == INGRESS_ACCEPT) begin
                    errInc = 1'b1;
                end
                if (state_q == INGRESS_DISCARD) begin
                    dropInc = 2'd1;
                end
                wrPtr_d = commitPtr_q;
                if (addrMatch) begin
                    ramWe    = 1'b1;
                    ramWaddr = commitPtr_q[PW-2:0];
                    wrPtr_d  = commitPtr_q + PTR_ONE;
                    if (in_endofpacket) begin
                        commitPtr_d = commitPtr_q + PTR_ONE;
                        commitInc   = 1'b1;
                        state_d     = INGRESS_IDLE;
                    end else begin
                        state_d = INGRESS_ACCEPT;
                    end
                end else if (in_endofpacket) begin
                    dropInc = dropInc + 2'd1;
                    state_d = INGRESS_IDLE;
                end else begin
                    state_d = INGRESS_DISCARD;
                end
            end else begin
                case (state_q)
                    INGRESS_IDLE: errInc = 1'b1;
                    INGRESS_ACCEPT: begin
                        ramWe   = 1'b1;
                        wrPtr_d = wrPtr_q + PTR_ONE;
                        if (in_endofpacket) begin
                            commitPtr_d = wrPtr_q + PTR_ONE;
                            commitInc   = 1'b1;
                            state_d     = INGRESS_IDLE;
                        end
                    end
                    INGRESS_DISCARD: begin
                        if (in_endofpacket) begin
                            dropInc = 2'd1;
                            state_d = INGRESS_IDLE;
                        end
                    end
                    default: state_d = INGRESS_IDLE;
                endcase
            end
        end
    end

    // Two-stage read pipe: RAM output register, then the output register
    always_comb begin
        load2  = !outValid_q || out_ready;
        ramRe  = (rdPtr_q != commitPtr_q) && (!s1Valid_q || load2);
        rdPtr_d = ramRe ? rdPtr_q + PTR_ONE : rdPtr_q;
        popEop = outValid_q && out_ready && outEop_q;
        {ramData, ramEmpty, ramEop} = ramRdata;
        case ({commitInc, popEop})
            2'b10:   pending_d = pending_q + PTR_ONE;
            2'b01:   pending_d = pending_q - PTR_ONE;
            default: pending_d = pending_q;
        endcase
    end

    dircc_ingress_beat_ram #(
        .WIDTH(ENTRY_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_beat_ram (
        .clk     (clk),
        .wrEn_i  (ramWe),
        .wrAddr_i(ramWaddr),
        .wrData_i({in_data, in_empty, in_endofpacket}),
        .rdEn_i  (ramRe),
        .rdAddr_i(rdPtr_q[PW-2:0]),
        .rdData_o(ramRdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INGRESS_IDLE;
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            pending_q   <= '0;
            dropCnt_q   <= '0;
            errCnt_q    <= '0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            pending_q   <= pending_d;
            dropCnt_q   <= satAdd(dropCnt_q, dropInc);
            errCnt_q    <= satAdd(errCnt_q, {1'b0, errInc});
            alive_q     <= 1'b1;
        end
    end

    // sopNext_q marks that the next beat to present opens a packet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
            outEop_q   <= 1'b0;
            outData_q  <= '0;
            outEmpty_q <= '0;
            sopNext_q  <= 1'b1;
        end else begin
            if (ramRe) begin
                s1Valid_q <= 1'b1;
            end else if (load2) begin
                s1Valid_q <= 1'b0;
            end
            if (load2) begin
                outValid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    outData_q  <= ramData;
                    outEmpty_q <= ramEmpty;
                    outEop_q   <= ramEop;
                    outSop_q   <= sopNext_q;
                    sopNext_q  <= ramEop;
                end
            end
        end
    end

    assign in_ready          = inReady;
    assign out_data          = outData_q;
    assign out_empty         = outEmpty_q;
    assign out_startofpacket = outSop_q;
    assign out_endofpacket   = outEop_q;
    assign out_valid         = outValid_q;
    assign drop_count        = dropCnt_q;
    assign error_count       = errCnt_q;
    assign packets_pending   = pending_q;

endmodule

// File: tb/tb_dircc_packet_ingress_buffer.sv
// Directed bench for dircc_packet_ingress_buffer: filtering, overflow,
// store-and-forward under stall, malformed packets and mid-run reset.
`timescale 1ns/1ps
module tb_dircc_packet_ingress_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic [1:0]  in_empty;
    logic        in_startofpacket, in_endofpacket, in_valid, in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_empty;
    logic        out_startofpacket, out_endofpacket, out_valid, out_ready;
    logic [31:0] address;
    logic [15:0] drop_count, error_count;
    logic [4:0]  packets_pending;

    int checks = 0;
    int errors = 0;
    logic [35:0] outQ[$];

    dircc_packet_ingress_buffer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_empty        (out_empty),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .address          (address),
        .drop_count       (drop_count),
        .error_count      (error_count),
        .packets_pending  (packets_pending)
    );

    always #5 clk = ~clk;

    // Record every downstream handshake as {sop, eop, empty, data}
    always begin
        @(negedge clk);
        #1;
        if (reset_n && out_valid && out_ready) begin
            outQ.push_back({out_startofpacket, out_endofpacket, out_empty, out_data});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [35:0] beatAt(input int i);
        if (i < outQ.size()) return outQ[i];
        return 'x;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred
    task automatic applyStimulus(input logic [31:0] data, input logic sop, input logic eop,
                                 input logic [1:0] empty);
        int waitCnt;
        in_data          = data;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_empty         = empty;
        in_valid         = 1'b1;
        waitCnt          = 0;
        while (!in_ready && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt == 64) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_empty         = 2'd0;
    endtask

    initial begin
        reset_n = 1'b0;
        in_data = '0; in_empty = '0; in_startofpacket = 0; in_endofpacket = 0; in_valid = 0;
        out_ready = 1'b0;
        address = 32'h12;
        tick(3);

        // Reset state
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_outs", 64'({out_valid, out_startofpacket, out_endofpacket, out_empty, out_data}), 64'd0);
        checkOutput("rst_counts", 64'({drop_count, error_count, packets_pending}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Matching 3-beat packet with exact output latency
        out_ready = 1'b1;
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hA001, 0, 0, 2'd0);
        applyStimulus(32'hA002, 0, 1, 2'd1);
        checkOutput("t1_lat_n0", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("t1_lat_n1", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("t1_lat_n2", 64'({out_valid, out_startofpacket, out_data}), 64'({1'b1, 1'b1, 32'h12}));
        tick(4);
        checkOutput("t1_count", 64'(outQ.size()), 64'd3);
        checkOutput("t1_b0", 64'(beatAt(0)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t1_b1", 64'(beatAt(1)), 64'({1'b0, 1'b0, 2'd0, 32'hA001}));
        checkOutput("t1_b2", 64'(beatAt(2)), 64'({1'b0, 1'b1, 2'd1, 32'hA002}));
        checkOutput("t1_drop", 64'(drop_count), 64'd0);
        checkOutput("t1_pending", 64'(packets_pending), 64'd0);
        outQ.delete();

        // Filtered 4-beat packet
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_in_ready", 64'(in_ready), 64'd1);
            applyStimulus((i == 0) ? 32'h99 : 32'h9900 + 32'(i), i == 0, i == 3, 2'd0);
        end
        tick(4);
        checkOutput("t2_no_output", 64'(outQ.size()), 64'd0);
        checkOutput("t2_drop", 64'(drop_count), 64'd1);
        checkOutput("t2_err", 64'(error_count), 64'd0);

        // Oversize 20-beat packet while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i == 0) ? 32'h12 : 32'hB000 + 32'(i), i == 0, i == 19, 2'd0);
        end
        tick(3);
        checkOutput("t3_err", 64'(error_count), 64'd1);
        checkOutput("t3_drop", 64'(drop_count), 64'd2);
        checkOutput("t3_pending", 64'(packets_pending), 64'd0);
        checkOutput("t3_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hC001, 0, 1, 2'd0);
        tick(6);
        checkOutput("t3_follow_count", 64'(outQ.size()), 64'd2);
        checkOutput("t3_follow_b0", 64'(beatAt(0)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t3_follow_b1", 64'(beatAt(1)), 64'({1'b0, 1'b1, 2'd0, 32'hC001}));
        outQ.delete();

        // Store-and-forward: two packets held, second one stalled mid-packet
        out_ready = 1'b0;
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hD001, 0, 1, 2'd0);
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hE001, 0, 0, 2'd0);
        tick(3);
        applyStimulus(32'hE002, 0, 0, 2'd0);
        applyStimulus(32'hE003, 0, 0, 2'd0);
        applyStimulus(32'hE004, 0, 1, 2'd3);
        checkOutput("t4_pending2", 64'(packets_pending), 64'd2);
        checkOutput("t4_held_head", 64'({out_valid, out_startofpacket, out_data}), 64'({1'b1, 1'b1, 32'h12}));
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            out_ready = !out_ready;
        end
        out_ready = 1'b1;
        tick(4);
        checkOutput("t4_count", 64'(outQ.size()), 64'd7);
        checkOutput("t4_a0", 64'(beatAt(0)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t4_a1", 64'(beatAt(1)), 64'({1'b0, 1'b1, 2'd0, 32'hD001}));
        checkOutput("t4_b0", 64'(beatAt(2)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t4_b1", 64'(beatAt(3)), 64'({1'b0, 1'b0, 2'd0, 32'hE001}));
        checkOutput("t4_b2", 64'(beatAt(4)), 64'({1'b0, 1'b0, 2'd0, 32'hE002}));
        checkOutput("t4_b3", 64'(beatAt(5)), 64'({1'b0, 1'b0, 2'd0, 32'hE003}));
        checkOutput("t4_b4", 64'(beatAt(6)), 64'({1'b0, 1'b1, 2'd3, 32'hE004}));
        checkOutput("t4_pending0", 64'(packets_pending), 64'd0);
        outQ.delete();

        // Truncated packet followed by a new sop, then stray beat and single-beat packets
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hF001, 0, 0, 2'd0);
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'hF101, 0, 1, 2'd0);
        tick(5);
        checkOutput("t5_err", 64'(error_count), 64'd2);
        checkOutput("t5_count", 64'(outQ.size()), 64'd2);
        checkOutput("t5_b0", 64'(beatAt(0)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t5_b1", 64'(beatAt(1)), 64'({1'b0, 1'b1, 2'd0, 32'hF101}));
        outQ.delete();
        applyStimulus(32'h5555, 0, 0, 2'd0);
        @(negedge clk);
        checkOutput("t5_stray_err", 64'(error_count), 64'd3);
        applyStimulus(32'h77, 1, 1, 2'd0);
        applyStimulus(32'h12, 1, 1, 2'd2);
        tick(4);
        checkOutput("t5_single_drop", 64'(drop_count), 64'd3);
        checkOutput("t5_single_count", 64'(outQ.size()), 64'd1);
        checkOutput("t5_single_b0", 64'(beatAt(0)), 64'({1'b1, 1'b1, 2'd2, 32'h12}));
        outQ.delete();

        // Reset while a complete packet is held
        out_ready = 1'b0;
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'h6001, 0, 0, 2'd0);
        applyStimulus(32'h6002, 0, 1, 2'd0);
        tick(3);
        checkOutput("t6_held", 64'({out_valid, packets_pending}), 64'({1'b1, 5'd1}));
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_outs", 64'({out_valid, out_startofpacket, out_endofpacket, out_empty, out_data}), 64'd0);
        checkOutput("t6_rst_counts", 64'({drop_count, error_count, packets_pending}), 64'd0);
        checkOutput("t6_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        applyStimulus(32'h12, 1, 0, 2'd0);
        applyStimulus(32'h7001, 0, 1, 2'd0);
        tick(6);
        checkOutput("t6_count", 64'(outQ.size()), 64'd2);
        checkOutput("t6_b0", 64'(beatAt(0)), 64'({1'b1, 1'b0, 2'd0, 32'h12}));
        checkOutput("t6_b1", 64'(beatAt(1)), 64'({1'b0, 1'b1, 2'd0, 32'h7001}));
        checkOutput("t6_err", 64'(error_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
